// File: rtl/fetch_ctrl.sv
// Fetch-stage sequencer: owns PC_F, issues one imem request at a time, and fills IF/ID.
// Optional performance counters are compiled in when FETCH_PERF_EN is defined.
module fetch_ctrl #(
  parameter logic [63:0] RESET_PC  = 64'h0,
  parameter logic [31:0] NOP_INSTR = 32'h00000013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        Stall_D,
  input  logic        PCSrc_E,
  input  logic [63:0] PCTarget_E,
  output logic        imem_req,
  output logic [63:0] imem_addr,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [63:0] PC_F,
  output logic [63:0] PC_D,
  output logic [31:0] Instr_D,
  output logic        Valid_D
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0] perf_fetched,
  output logic [31:0] perf_flushed,
  output logic [31:0] perf_wait
`endif
);

  typedef enum logic [1:0] {
    ST_ISSUE = 2'd0,
    ST_WAIT  = 2'd1,
    ST_HOLD  = 2'd2,
    ST_DROP  = 2'd3
  } state_t;

  state_t      state_r;
  state_t      state_s;
  logic [63:0] buf_pc_r;
  logic [31:0] buf_instr_r;
  logic [63:0] redir_pc_s;
  logic        write_resp_s;
  logic        write_buf_s;
  logic        capture_s;
  logic        discard_s;

  // Redirect targets are forced to a 4-byte boundary.
  assign redir_pc_s = PCTarget_E & ~64'h3;
  assign imem_addr  = PC_F;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_ISSUE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state logic; a redirect outranks stalls in every state.
  always_comb begin
    state_s = ST_ISSUE;
    case (state_r)
      ST_ISSUE: begin
        if (PCSrc_E) state_s = ST_ISSUE;
        else         state_s = ST_WAIT;
      end
      ST_WAIT: begin
        if (PCSrc_E)          state_s = imem_rvalid ? ST_ISSUE : ST_DROP;
        else if (imem_rvalid) state_s = Stall_D ? ST_HOLD : ST_ISSUE;
        else                  state_s = ST_WAIT;
      end
      ST_HOLD: begin
        if (PCSrc_E)      state_s = ST_ISSUE;
        else if (Stall_D) state_s = ST_HOLD;
        else              state_s = ST_ISSUE;
      end
      ST_DROP: begin
        if (imem_rvalid) state_s = ST_ISSUE;
        else             state_s = ST_DROP;
      end
      default: state_s = ST_ISSUE;
    endcase
  end

  // Per-cycle action decode.
  always_comb begin
    imem_req     = 1'b0;
    write_resp_s = 1'b0;
    write_buf_s  = 1'b0;
    capture_s    = 1'b0;
    discard_s    = 1'b0;
    case (state_r)
      ST_ISSUE: imem_req = ~PCSrc_E & ~rst;
      ST_WAIT: begin
        write_resp_s = imem_rvalid & ~Stall_D & ~PCSrc_E;
        capture_s    = imem_rvalid &  Stall_D & ~PCSrc_E;
        discard_s    = imem_rvalid &  PCSrc_E;
      end
      ST_HOLD: begin
        write_buf_s = ~Stall_D & ~PCSrc_E;
        discard_s   = PCSrc_E;
      end
      ST_DROP: discard_s = imem_rvalid;
      default: imem_req = 1'b0;
    endcase
  end

  // Fetch PC and the single-entry response buffer.
  always_ff @(posedge clk) begin
    if (rst) begin
      PC_F        <= RESET_PC;
      buf_pc_r    <= 64'h0;
      buf_instr_r <= NOP_INSTR;
    end else begin
      if (PCSrc_E)                          PC_F <= redir_pc_s;
      else if (write_resp_s || write_buf_s) PC_F <= PC_F + 64'd4;
      else                                  PC_F <= PC_F;
      if (capture_s) begin
        buf_pc_r    <= PC_F;
        buf_instr_r <= imem_rdata;
      end else begin
        buf_pc_r    <= buf_pc_r;
        buf_instr_r <= buf_instr_r;
      end
    end
  end

  // IF/ID register: flush, real write, bubble or hold, in that priority.
  always_ff @(posedge clk) begin
    if (rst) begin
      PC_D    <= 64'h0;
      Instr_D <= NOP_INSTR;
      Valid_D <= 1'b0;
    end else if (PCSrc_E) begin
      Instr_D <= NOP_INSTR;
      Valid_D <= 1'b0;
    end else if (write_resp_s) begin
      PC_D    <= PC_F;
      Instr_D <= imem_rdata;
      Valid_D <= 1'b1;
    end else if (write_buf_s) begin
      PC_D    <= buf_pc_r;
      Instr_D <= buf_instr_r;
      Valid_D <= 1'b1;
    end else if (!Stall_D) begin
      Instr_D <= NOP_INSTR;
      Valid_D <= 1'b0;
    end else begin
      Valid_D <= Valid_D;
    end
  end

`ifdef FETCH_PERF_EN
  // Free-running event counters, wrapping at 2^32.
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_fetched <= 32'd0;
      perf_flushed <= 32'd0;
      perf_wait    <= 32'd0;
    end else begin
      perf_fetched <= perf_fetched + {31'd0, write_resp_s | write_buf_s};
      perf_flushed <= perf_flushed + {31'd0, discard_s};
      perf_wait    <= perf_wait + {31'd0, (state_r == ST_WAIT) || (state_r == ST_DROP)};
    end
  end
`endif

endmodule

// File: tb/tb_fetch_ctrl.sv
// Randomized scoreboard bench for fetch_ctrl with a variable-latency imem and a
// transaction-level reference model of the fetch stream.
module tb_fetch_ctrl;
  localparam logic [63:0] RPC = 64'h1000;
  localparam logic [31:0] NOP = 32'h00000013;

  logic        clk = 1'b0;
  logic        rst, stall, redir, rvalid, req, Valid_D;
  logic [63:0] target, addr, PC_F, PC_D;
  logic [31:0] rdata, Instr_D;
`ifdef FETCH_PERF_EN
  logic [31:0] perf_fetched, perf_flushed, perf_wait;
`endif

  fetch_ctrl #(.RESET_PC(RPC), .NOP_INSTR(NOP)) dut (
    .clk(clk), .rst(rst), .Stall_D(stall), .PCSrc_E(redir), .PCTarget_E(target),
    .imem_req(req), .imem_addr(addr), .imem_rvalid(rvalid), .imem_rdata(rdata),
    .PC_F(PC_F), .PC_D(PC_D), .Instr_D(Instr_D), .Valid_D(Valid_D)
`ifdef FETCH_PERF_EN
    , .perf_fetched(perf_fetched), .perf_flushed(perf_flushed), .perf_wait(perf_wait)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed { logic [63:0] pc; logic [31:0] ins; } ent_t;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: fetch PC, whether a fetch may start, one in-flight request
  // (wanted or to be discarded) and at most one parked instruction.
  logic [63:0] m_pc;
  bit          m_ready, m_inflight, m_keep;
  ent_t        m_buf[$];
  ent_t        exp_wr[$];
  logic [63:0] exp_req[$];
  int          m_fetched, m_flushed, m_wait;

  int          im_cnt = 0;
  logic [63:0] im_addr;
  int          fixed_lat = 1;

  function automatic logic [31:0] mem_fn(input logic [63:0] a);
    return (a[31:0] * 32'h9E3779B1) ^ a[63:32] ^ 32'h00005A5A;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic model_step(input bit r, input bit s, input bit d, input logic [63:0] t, input bit v);
    bit   issue;
    ent_t e;
    if (r) begin
      m_pc = RPC; m_ready = 1; m_inflight = 0; m_keep = 0; m_buf.delete();
      m_fetched = 0; m_flushed = 0; m_wait = 0;
      return;
    end
    if (m_inflight) m_wait++;
    issue = m_ready && !d;
    if (d) begin
      m_pc = {t[63:2], 2'b00};
      if (m_buf.size() != 0) begin
        m_buf.delete(); m_ready = 1; m_flushed++;
      end else if (m_inflight) begin
        if (v) begin m_inflight = 0; m_ready = 1; m_flushed++; end
        else m_keep = 0;
      end
    end else if (m_inflight && v) begin
      m_inflight = 0;
      if (!m_keep) begin
        m_ready = 1; m_flushed++;
      end else begin
        e.pc = m_pc; e.ins = mem_fn(m_pc);
        if (s) m_buf.push_back(e);
        else begin exp_wr.push_back(e); m_pc += 64'd4; m_ready = 1; m_fetched++; end
      end
    end else if (m_buf.size() != 0 && !s) begin
      exp_wr.push_back(m_buf.pop_front()); m_pc += 64'd4; m_ready = 1; m_fetched++;
    end
    if (issue) begin
      exp_req.push_back(m_pc); m_ready = 0; m_inflight = 1; m_keep = 1;
    end
  endtask

  // One clock of stimulus: drive inputs, play the imem, advance the model.
  task automatic cycle(input bit r, input bit s, input bit d, input logic [63:0] t);
    @(negedge clk);
    rst = r; stall = s; redir = d; target = t;
    if (r) begin
      im_cnt = 0; rvalid = 1'b0; rdata = 32'h0;
    end else if (im_cnt == 1) begin
      rvalid = 1'b1; rdata = mem_fn(im_addr); im_cnt = 0;
    end else begin
      rvalid = 1'b0; rdata = $urandom;
      if (im_cnt > 1) im_cnt--;
    end
    #1;
    if (!r) check("pc_f", PC_F, m_pc);
`ifdef FETCH_PERF_EN
    if (!r) begin
      check("perf_fetched", {32'h0, perf_fetched}, 64'(unsigned'(m_fetched)));
      check("perf_flushed", {32'h0, perf_flushed}, 64'(unsigned'(m_flushed)));
      check("perf_wait",    {32'h0, perf_wait},    64'(unsigned'(m_wait)));
    end
`endif
    if (req === 1'b1 && !r) begin
      im_cnt  = (fixed_lat != 0) ? fixed_lat : int'($urandom_range(1, 4));
      im_addr = addr;
    end
    model_step(r, s, d, t, rvalid);
  endtask

  task automatic wait_inflight();
    int k = 0;
    while (!m_inflight && k < 20) begin cycle(0, 0, 0, 64'h0); k++; end
    n_vec++;
    if (!m_inflight) begin n_err++; $display("FAIL wait_timeout: got idle expected request"); end
  endtask

  // Monitor: checks every request and every new IF/ID entry against the scoreboard.
  initial begin
    bit   last_s = 1, last_d = 0, last_r = 1;
    ent_t e;
    forever begin
      @(negedge clk); #2;
      if (rst === 1'b1) check("req_in_reset", {63'h0, req}, 64'h0);
      if (!last_r) begin
        if (last_d) check("flush_valid", {63'h0, Valid_D}, 64'h0);
        if (!Valid_D) check("bubble_nop", {32'h0, Instr_D}, {32'h0, NOP});
        if (Valid_D && !last_s && !last_d) begin
          if (exp_wr.size() == 0) begin
            n_vec++; n_err++;
            $display("FAIL unexpected_write: got pc %h instr %h expected none", PC_D, Instr_D);
          end else begin
            e = exp_wr.pop_front();
            check("pc_d", PC_D, e.pc);
            check("instr_d", {32'h0, Instr_D}, {32'h0, e.ins});
          end
        end
      end
      if (req === 1'b1) begin
        if (exp_req.size() == 0) begin
          n_vec++; n_err++;
          $display("FAIL unexpected_req: got addr %h expected none", addr);
        end else check("imem_addr", addr, exp_req.pop_front());
      end
      last_s = stall; last_d = redir; last_r = rst;
    end
  end

  initial begin
    int k;
    rst = 1; stall = 0; redir = 0; target = 0; rvalid = 0; rdata = 0;
    cycle(1, 0, 0, 64'h0);
    cycle(1, 0, 0, 64'h0);
    check("rst_pc_f", PC_F, RPC);
    check("rst_pc_d", PC_D, 64'h0);
    check("rst_valid", {63'h0, Valid_D}, 64'h0);
    check("rst_instr", {32'h0, Instr_D}, {32'h0, NOP});
    // Latency 1, no stalls: 0x1000, 0x1004, 0x1008 ...
    repeat (8) cycle(0, 0, 0, 64'h0);
    // Stall across a response: buffered, then released.
    wait_inflight();
    repeat (3) cycle(0, 1, 0, 64'h0);
    repeat (4) cycle(0, 0, 0, 64'h0);
    // Redirect during a long wait: late response must be dropped.
    fixed_lat = 4;
    wait_inflight();
    cycle(0, 0, 1, 64'h2002);
    repeat (10) cycle(0, 0, 0, 64'h0);
    // Redirect together with a stall while holding a buffered response.
    fixed_lat = 1;
    wait_inflight();
    repeat (2) cycle(0, 1, 0, 64'h0);
    cycle(0, 1, 1, 64'h3000);
    repeat (6) cycle(0, 0, 0, 64'h0);
    // PC wrap at the top of the address space.
    wait_inflight();
    cycle(0, 0, 0, 64'h0);
    cycle(0, 0, 1, 64'hFFFF_FFFF_FFFF_FFFC);
    repeat (10) cycle(0, 0, 0, 64'h0);
    // Random traffic, then a mid-run reset and more random traffic.
    fixed_lat = 0;
    for (int i = 0; i < 2000; i++) begin
      if (i == 1400) begin
        cycle(1, 0, 0, 64'h0);
        cycle(1, 0, 0, 64'h0);
      end
      cycle(0, $urandom_range(0, 9) < 3, $urandom_range(0, 19) == 0,
            ($urandom_range(0, 3) == 0) ? {32'hFFFF_FFFF, 28'hFFFF_FFF, 4'($urandom)} : {$urandom, $urandom});
    end
    k = 0;
    while ((exp_wr.size() != 0 || m_inflight || m_buf.size() != 0) && k < 100) begin
      cycle(0, 0, 0, 64'h0); k++;
    end
    repeat (3) cycle(0, 0, 0, 64'h0);
    check("drain_writes", 64'(exp_wr.size()), 64'h0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
